// File: rtl/uart_word_tx_if.sv
// Word handshake between the processing core and the UART word transmitter.
// The core (master) presents words; the transmitter (slave) drives the line and status.
interface uart_word_tx_if;
   logic [15:0] data_in;
   logic        data_in_valid;
   logic        tx_done;
   logic        tx_serial;
   logic        tx_active;

   modport master (
      output data_in,
      output data_in_valid,
      input  tx_done,
      input  tx_serial,
      input  tx_active
   );

   modport slave (
      input  data_in,
      input  data_in_valid,
      output tx_done,
      output tx_serial,
      output tx_active
   );
endinterface

// File: rtl/uart_word_tx.sv
// Sends each accepted 16-bit word as two back-to-back 8N1 UART bytes.
// tx_done high means idle; its rising edge cues the core for the next word.
module uart_word_tx #(
   parameter int CLKS_PER_BIT   = 16,
   parameter bit LSB_BYTE_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rstb,
   uart_word_tx_if.slave tx_if
);

   localparam int            CW     = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          byte_sel_q, byte_sel_d;
   logic [15:0]   hold_q, hold_d;
   logic          valid_prev_q;
   logic          tx_serial_q, tx_serial_d;
   logic          tx_done_q, tx_done_d;
   logic          tx_active_q, tx_active_d;

   logic          accept;
   logic          tick;
   logic [7:0]    cur_byte;

   // Only a fresh rising edge of valid, seen while idle, starts a word.
   assign accept = (state_q == IDLE) && tx_if.data_in_valid && !valid_prev_q;
   assign tick   = (cnt_q == '0);

   // State register and datapath
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         byte_sel_q   <= 1'b0;
         hold_q       <= '0;
         valid_prev_q <= 1'b0;
         tx_serial_q  <= 1'b1;
         tx_done_q    <= 1'b0;
         tx_active_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         byte_sel_q   <= byte_sel_d;
         hold_q       <= hold_d;
         valid_prev_q <= tx_if.data_in_valid;
         tx_serial_q  <= tx_serial_d;
         tx_done_q    <= tx_done_d;
         tx_active_q  <= tx_active_d;
      end
   end

   // Next-state logic; every bit period is CLKS_PER_BIT cycles of the down-counter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      byte_sel_d = byte_sel_q;
      hold_d     = hold_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               cnt_d      = RELOAD;
               bit_d      = '0;
               byte_sel_d = 1'b0;
               hold_d     = tx_if.data_in;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               cnt_d   = RELOAD;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d = RELOAD;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (tick) begin
               if (!byte_sel_q) begin
                  state_d    = START;
                  byte_sel_d = 1'b1;
                  cnt_d      = RELOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the line never glitches.
   always_comb begin
      cur_byte    = (byte_sel_d == LSB_BYTE_FIRST) ? hold_d[15:8] : hold_d[7:0];
      tx_serial_d = 1'b1;
      tx_done_d   = 1'b0;
      tx_active_d = 1'b1;
      case (state_d)
         IDLE: begin
            tx_done_d   = 1'b1;
            tx_active_d = 1'b0;
         end
         START:   tx_serial_d = 1'b0;
         DATA:    tx_serial_d = cur_byte[bit_d];
         STOP:    tx_serial_d = 1'b1;
         default: tx_serial_d = 1'b1;
      endcase
   end

   assign tx_if.tx_serial = tx_serial_q;
   assign tx_if.tx_done   = tx_done_q;
   assign tx_if.tx_active = tx_active_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (CPB 4 / 1 / 3, the last MSB byte first),
// table vectors, hand sequences and random words checked against a frame model.
module tb_uart_word_tx;

   typedef struct {
      int          u;
      logic [15:0] w;
      logic [7:0]  b0;
      logic [7:0]  b1;
      bit          hold;
      bit          glitch;
      string       nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [15:0] din [3];
   logic        vld [3];
   logic        ser [3];
   logic        done[3];
   logic        act [3];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_word_tx_if if0 ();
   uart_word_tx_if if1 ();
   uart_word_tx_if if2 ();

   assign if0.data_in = din[0];  assign if0.data_in_valid = vld[0];
   assign if1.data_in = din[1];  assign if1.data_in_valid = vld[1];
   assign if2.data_in = din[2];  assign if2.data_in_valid = vld[2];
   assign ser[0] = if0.tx_serial; assign done[0] = if0.tx_done; assign act[0] = if0.tx_active;
   assign ser[1] = if1.tx_serial; assign done[1] = if1.tx_done; assign act[1] = if1.tx_active;
   assign ser[2] = if2.tx_serial; assign done[2] = if2.tx_done; assign act[2] = if2.tx_active;

   uart_word_tx #(.CLKS_PER_BIT(4), .LSB_BYTE_FIRST(1'b1)) u0 (.clk(clk), .rstb(rstb), .tx_if(if0));
   uart_word_tx #(.CLKS_PER_BIT(1), .LSB_BYTE_FIRST(1'b1)) u1 (.clk(clk), .rstb(rstb), .tx_if(if1));
   uart_word_tx #(.CLKS_PER_BIT(3), .LSB_BYTE_FIRST(1'b0)) u2 (.clk(clk), .rstb(rstb), .tx_if(if2));

   function automatic int cpb_of(input int u);
      case (u)
         0:       return 4;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic bit lsbf(input int u);
      return (u != 2);
   endfunction

   // Whole-word line image, index 0 = first bit period on the wire.
   function automatic logic [19:0] frame_of(input int u, input logic [15:0] w);
      logic [7:0] f, s;
      f = lsbf(u) ? w[7:0]  : w[15:8];
      s = lsbf(u) ? w[15:8] : w[7:0];
      return {1'b1, s, 1'b0, 1'b1, f, 1'b0};
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   // Called on a negedge; returns on the negedge where tx_done should be back high.
   task automatic send_word(input vec_t v, output int acc);
      int          u, cpb, tmo, nbad, nhs;
      logic [19:0] fr;
      logic [7:0]  d0, d1;
      logic        lv[$];
      u = v.u; cpb = cpb_of(u); fr = frame_of(u, v.w);
      nbad = 0; nhs = 0; tmo = 0;
      while (done[u] !== 1'b1 && tmo < 1000) begin
         @(negedge clk);
         tmo++;
      end
      chk(done[u] === 1'b1, {v.nm, " ready"}, 32'(done[u]), 32'd1);
      din[u] = v.w;
      vld[u] = 1'b1;
      acc = cyc;
      @(negedge clk);
      if (!v.hold) vld[u] = 1'b0;
      for (int k = 0; k < 20*cpb; k++) begin
         lv.push_back(ser[u]);
         if (ser[u] !== fr[k/cpb]) nbad++;
         if (done[u] !== 1'b0 || act[u] !== 1'b1) nhs++;
         if (v.glitch && k == 30) begin din[u] = 16'hFFFF; vld[u] = 1'b1; end
         if (v.glitch && k == 33) begin din[u] = 16'h0000; vld[u] = 1'b0; end
         @(negedge clk);
      end
      chk(nbad == 0, {v.nm, " line"}, 32'(nbad), 32'd0);
      chk(nhs == 0, {v.nm, " busy"}, 32'(nhs), 32'd0);
      chk(done[u] === 1'b1 && act[u] === 1'b0 && ser[u] === 1'b1, {v.nm, " idle"},
          32'({done[u], act[u], ser[u]}), 32'b101);
      for (int i = 0; i < 8; i++) begin
         d0[i] = lv[(1 + i)*cpb + cpb/2];
         d1[i] = lv[(11 + i)*cpb + cpb/2];
      end
      chk(d0 === v.b0, {v.nm, " byte0"}, 32'(d0), 32'(v.b0));
      chk(d1 === v.b1, {v.nm, " byte1"}, 32'(d1), 32'(v.b1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      vec_t v;
      int   acc, prev, nidle;

      tbl.push_back('{0, 16'hA55A, 8'h5A, 8'hA5, 1'b0, 1'b0, "a55a_lsb"});
      tbl.push_back('{0, 16'h1234, 8'h34, 8'h12, 1'b1, 1'b0, "held_valid"});
      tbl.push_back('{0, 16'h1234, 8'h34, 8'h12, 1'b0, 1'b1, "busy_edge"});
      tbl.push_back('{1, 16'h0001, 8'h01, 8'h00, 1'b0, 1'b0, "b2b_0001"});
      tbl.push_back('{1, 16'h8000, 8'h00, 8'h80, 1'b0, 1'b0, "b2b_8000"});
      tbl.push_back('{1, 16'h00FF, 8'hFF, 8'h00, 1'b0, 1'b0, "b2b_00ff"});
      tbl.push_back('{2, 16'hA55A, 8'hA5, 8'h5A, 1'b0, 1'b0, "a55a_msb"});

      for (int u = 0; u < 3; u++) begin
         din[u] = 16'h0;
         vld[u] = 1'b0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int u = 0; u < 3; u++)
         chk(done[u] === 1'b0 && ser[u] === 1'b1 && act[u] === 1'b0, "reset outputs",
             32'({done[u], act[u], ser[u]}), 32'b001);
      rstb = 1'b1;
      #1 chk(done[0] === 1'b0, "done before first edge", 32'(done[0]), 32'd0);
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++)
         chk(done[u] === 1'b1, "done after first edge", 32'(done[u]), 32'd1);
      @(negedge clk);

      prev = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         send_word(tbl[i], acc);
         if (i == 4 || i == 5)
            chk(acc - prev == 21, {tbl[i].nm, " period"}, 32'(acc - prev), 32'd21);
         prev = acc;
         if (tbl[i].hold) begin
            nidle = 0;
            for (int k = 0; k < 120; k++) begin
               if (ser[0] !== 1'b1 || done[0] !== 1'b1) nidle++;
               @(negedge clk);
            end
            chk(nidle == 0, "held valid no retrigger", 32'(nidle), 32'd0);
            vld[0] = 1'b0;
            @(negedge clk);
         end
      end

      // Reset in the middle of byte 1 of 0xBEEF, while the line is low
      din[0] = 16'hBEEF;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (45) @(negedge clk);
      chk(ser[0] === 1'b0, "pre-reset line", 32'(ser[0]), 32'd0);
      #2 rstb = 1'b0;
      #1 chk(ser[0] === 1'b1, "async reset line", 32'(ser[0]), 32'd1);
      chk(done[0] === 1'b0 && act[0] === 1'b0, "async reset status",
          32'({done[0], act[0]}), 32'd0);
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      #1 chk(done[0] === 1'b0, "done low after release", 32'(done[0]), 32'd0);
      @(posedge clk);
      #1 chk(done[0] === 1'b1, "done rises after release", 32'(done[0]), 32'd1);
      @(negedge clk);
      v = '{0, 16'hCAFE, 8'hFE, 8'hCA, 1'b0, 1'b0, "cafe_after_reset"};
      send_word(v, acc);

      // Random words on every instance
      for (int i = 0; i < 9; i++) begin
         v.u      = i % 3;
         v.w      = 16'($urandom);
         v.b0     = lsbf(v.u) ? v.w[7:0]  : v.w[15:8];
         v.b1     = lsbf(v.u) ? v.w[15:8] : v.w[7:0];
         v.hold   = 1'b0;
         v.glitch = 1'b0;
         v.nm     = "random";
         send_word(v, acc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Downstream transmit stage for the processing core. Takes each 16-bit result word from the core's data_out/data_out_valid and sends it on a single UART line as two 8N1 bytes.
- Reports readiness for the next word on tx_done. A rising edge on tx_done is the core's cue to present the next word.
- Single clock domain, posedge clk.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit. Legal range is 1 or greater; the bit counter width is $clog2(CLKS_PER_BIT+1).
- LSB_BYTE_FIRST, 1, 1 = send data_in[7:0] first, 0 = send data_in[15:8] first.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rstb  input  1  asynchronous active-low reset
- data_in  input  16  word to transmit (driven from core data_out)
- data_in_valid  input  1  word-present strobe (driven from core data_out_valid)
- tx_done  output  1  high = idle and ready for a word (drives core tx_done)
- tx_serial  output  1  UART line; idles high
- tx_active  output  1  high while a word is being serialized (status/debug)

Behaviour:
- Reset (rstb low, async): state=IDLE, tx_serial=1, tx_done=0, tx_active=0, valid_prev=0, shift/bit/clk counters=0.
- First posedge after rstb deasserts: tx_done goes 1. This gives the core a clean rising edge for its first word.
- States:
  - IDLE: tx_serial=1, tx_done=1.
  - START: tx_serial=0.
  - DATA: tx_serial=current bit, 8 bits, LSB first.
  - STOP: tx_serial=1.
  - byte_sel (0/1) tracks which byte is in flight.
- Accept rule: a word is accepted only in IDLE and only on a rising edge of data_in_valid (data_in_valid=1, valid_prev=0).
  - valid_prev updates every cycle in every state.
  - On the accepting edge, capture data_in into a 16-bit holding register.
  - Next cycle: tx_done=0, tx_active=1, state=START, tx_serial=0.
- data_in_valid held high does not retrigger. A rising edge seen outside IDLE is dropped. There is no queue and no error flag.
- Each of START, each data bit, and STOP lasts exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
- After STOP of byte 0, go straight to START of byte 1 with no idle gap. After STOP of byte 1, return to IDLE.
- Timing: one word = 20 bit periods.
  - Capture at edge N: tx_serial first goes low at N+1.
  - tx_done and tx_active return 1/0 at N+1+20*CLKS_PER_BIT.
  - tx_serial is high for the whole final CLKS_PER_BIT-cycle stop period.
- Back-to-back: a rising edge of data_in_valid in the very cycle tx_done returns to 1 is accepted. Minimum word period is 20*CLKS_PER_BIT+1 cycles.
- Byte order:
  - LSB_BYTE_FIRST=1: data_in[7:0], then data_in[15:8].
  - LSB_BYTE_FIRST=0: reversed.
  - Bits within each byte are always LSB first.
- Reset mid-word: the line returns high immediately (async), the partial word is discarded, and the tx_done rising edge is regenerated after deassertion.
- CLKS_PER_BIT=1: every bit lasts one cycle. The counter must not underflow or skip bits.
- data_in changing after capture has no effect on the word in flight.

Test Plan:
- Reset release, CLKS_PER_BIT=4 -> tx_done=0 and tx_serial=1 during reset; tx_done=1 on first posedge after release.
- Send 0xA55A, CLKS_PER_BIT=4, LSB_BYTE_FIRST=1 -> line carries:
  - start, 0,1,0,1,1,0,1,0, stop
  - start, 1,0,1,0,0,1,0,1, stop
  - each level for 4 cycles; tx_done low for exactly 80 cycles.
  - A UART monitor decodes 0x5A then 0xA5.
- Held valid + busy edge -> hold data_in_valid high for 200 cycles with 0x1234: exactly one word is sent. Pulse valid with 0xFFFF mid-word: it is ignored and the line carries only 0x34, 0x12.
- Back-to-back words 0x0001, 0x8000, 0x00FF, each valid pulse on the cycle tx_done rises, CLKS_PER_BIT=1 -> 6 bytes, no gaps; each word period is 21 cycles.
- Reset mid-word (rstb low during DATA of byte 1, word 0xBEEF) -> tx_serial=1 immediately. After release, tx_done rises again and a fresh 0xCAFE is sent correctly.
- LSB_BYTE_FIRST=0, word 0xA55A -> bytes decoded as 0xA5 then 0x5A.
